// File: rtl/cordic_voice_sched.sv
// Time-multiplexes one CORDIC sine core across NUM_VOICES oscillators, one sample per enabled voice per frame.
// Phase is held in [-pi/2, pi/2] and folded with a negate flag so the core only ever sees a quarter-wave-safe angle.
module cordic_voice_sched #(
  parameter int NUM_VOICES = 8,
  parameter int VW         = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic [NUM_VOICES-1:0] voice_en,
  input  logic                  cfg_we,
  input  logic [VW-1:0]         cfg_voice,
  input  logic [29:0]           cfg_delta,
  output logic [23:0]           cordic_angle,
  output logic                  cordic_start,
  input  logic                  cordic_busy,
  input  logic                  cordic_out_valid,
  input  logic [15:0]           cordic_out,
  output logic                  smp_valid,
  output logic [VW-1:0]         smp_voice,
  output logic [15:0]           smp_data,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam logic [31:0] PI_HALF = 32'h3243F6A8;
  localparam logic [31:0] PI      = 32'h6487ED51;

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, EMIT} state_t;

  state_t                  state;
  logic [VW-1:0]           v;
  logic [31:0]             phase [NUM_VOICES];
  logic [NUM_VOICES-1:0]   neg;
  logic [29:0]             delta [NUM_VOICES];

  logic [31:0] cur_phase;
  logic [31:0] t_sum;
  logic        fold;
  logic        last;

  always_comb begin
    cur_phase = phase[v];
    t_sum     = cur_phase + {2'b00, delta[v]};
    fold      = !t_sum[31] && (t_sum > PI_HALF);
    last      = (v == VW'(NUM_VOICES - 1));
  end

  // Start is decoded from state so it tracks busy in the same cycle.
  assign cordic_start = (state == ISSUE) && !cordic_busy && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) delta[i] <= '0;
    end else if (cfg_we) begin
      delta[cfg_voice] <= cfg_delta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      v            <= '0;
      neg          <= '0;
      cordic_angle <= '0;
      smp_valid    <= 1'b0;
      smp_voice    <= '0;
      smp_data     <= '0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
    end else begin
      smp_valid  <= 1'b0;
      frame_done <= 1'b0;
      // The frame_done cycle still belongs to the finishing frame.
      if (sample_tick && (state != IDLE || frame_done)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick && !frame_done) begin
            state <= SCAN;
            v     <= '0;
          end
        end
        SCAN: begin
          if (voice_en[v]) begin
            state        <= ISSUE;
            cordic_angle <= cur_phase[30:7];
          end else if (last) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            v <= v + 1'b1;
          end
        end
        ISSUE: begin
          if (!cordic_busy) state <= WAIT;
        end
        WAIT: begin
          if (cordic_out_valid) begin
            state     <= EMIT;
            smp_valid <= 1'b1;
            smp_voice <= v;
            smp_data  <= neg[v] ? (~cordic_out + 16'd1) : cordic_out;
          end
        end
        EMIT: begin
          phase[v] <= fold ? (t_sum - PI) : t_sum;
          if (fold) neg[v] <= ~neg[v];
          if (last) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            state <= SCAN;
            v     <= v + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_voice_sched.sv
// Directed bench for cordic_voice_sched with a fixed-latency CORDIC core stub.
module tb_cordic_voice_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic [7:0]  voice_en = 8'h00;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_voice = 3'd0;
  logic [29:0] cfg_delta = 30'd0;
  logic [23:0] cordic_angle;
  logic        cordic_start;
  logic        cordic_busy;
  logic        cordic_out_valid = 1'b0;
  logic [15:0] cordic_out = 16'h4000;
  logic        smp_valid;
  logic [2:0]  smp_voice;
  logic [15:0] smp_data;
  logic        frame_done;
  logic        overrun;

  cordic_voice_sched #(.NUM_VOICES(8)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .voice_en(voice_en),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_delta(cfg_delta),
    .cordic_angle(cordic_angle), .cordic_start(cordic_start),
    .cordic_busy(cordic_busy), .cordic_out_valid(cordic_out_valid),
    .cordic_out(cordic_out), .smp_valid(smp_valid), .smp_voice(smp_voice),
    .smp_data(smp_data), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Core stub: busy for 20 cycles after a start, then a one-cycle valid.
  logic stub_busy = 1'b0;
  logic hold_busy = 1'b0;
  int   stub_cnt  = 0;
  assign cordic_busy = stub_busy | hold_busy;

  always @(posedge clk) begin
    cordic_out_valid <= 1'b0;
    if (cordic_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 20;
    end else if (stub_busy) begin
      if (stub_cnt == 1) begin
        stub_busy        <= 1'b0;
        cordic_out_valid <= 1'b1;
      end
      stub_cnt <= stub_cnt - 1;
    end
  end

  // Monitor: append-only logs, sampled on the falling edge.
  int          cyc = 0;
  int          done_cnt = 0;
  int          lat_bad = 0;
  int          start_busy_bad = 0;
  int          last_valid_cyc = -10;
  logic [2:0]  smp_v_q[$];
  logic [15:0] smp_d_q[$];
  logic [23:0] ang_q[$];
  int          start_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (smp_valid) begin
      smp_v_q.push_back(smp_voice);
      smp_d_q.push_back(smp_data);
      if (last_valid_cyc != cyc - 1) lat_bad = lat_bad + 1;
    end
    if (cordic_out_valid) last_valid_cyc = cyc;
    if (cordic_start) begin
      ang_q.push_back(cordic_angle);
      start_cyc_q.push_back(cyc);
      if (cordic_busy) start_busy_bad = start_busy_bad + 1;
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_delta(input logic [2:0] vi, input logic [29:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = vi; cfg_delta = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_tick(output int t0);
    @(negedge clk);
    sample_tick = 1'b1;
    t0 = cyc;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_done(output int done_at, output int got);
    got = 0;
    done_at = 0;
    for (int k = 0; k < 3000 && got == 0; k++) begin
      if (frame_done) begin
        got = 1;
        done_at = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic [7:0]  en;
    int          exp_n;
    logic [23:0] ang_first;
    logic [15:0] dat_first;
    logic [23:0] ang_last;
    logic [2:0]  voice_last;
  } row_t;

  row_t rows[7];

  initial begin
    int t0, done_at, got, n, bs, ba, bsc, bd;

    rows[0] = '{8'h01, 1, 24'h000000, 16'h4000, 24'h000000, 3'd0};
    rows[1] = '{8'h01, 1, 24'h400000, 16'h4000, 24'h400000, 3'd0};
    rows[2] = '{8'h01, 1, 24'hB6F025, 16'hC000, 24'hB6F025, 3'd0};
    rows[3] = '{8'h00, 0, 24'h000000, 16'h0000, 24'h000000, 3'd0};
    rows[4] = '{8'hFF, 8, 24'hF6F025, 16'hC000, 24'h000000, 3'd7};
    rows[5] = '{8'h05, 2, 24'h36F025, 16'hC000, 24'h004000, 3'd2};
    rows[6] = '{8'hFA, 6, 24'h002000, 16'h4000, 24'h00E000, 3'd7};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {27'd0, cordic_start, smp_valid, frame_done, overrun, smp_voice}, 32'd0);
    check("reset_data", {16'd0, smp_data}, 32'd0);
    check("reset_angle", {8'd0, cordic_angle}, 32'd0);

    write_delta(3'd0, 30'h20000000);
    for (int i = 0; i < 7; i++) begin
      if (i == 4) for (int k = 1; k < 8; k++) write_delta(3'(k), 30'(k) << 20);
      voice_en = rows[i].en;
      bs = smp_v_q.size(); ba = ang_q.size(); bsc = start_cyc_q.size(); bd = done_cnt;
      pulse_tick(t0);
      wait_done(done_at, got);
      repeat (2) @(negedge clk);
      check($sformatf("row%0d_done_seen", i), got, 1);
      check($sformatf("row%0d_done_count", i), done_cnt - bd, 1);
      n = smp_v_q.size() - bs;
      check($sformatf("row%0d_samples", i), n, rows[i].exp_n);
      if (rows[i].exp_n == 0)
        check($sformatf("row%0d_frame_len", i), done_at - t0, 9);
      if (rows[i].exp_n > 0 && n > 0) begin
        check($sformatf("row%0d_angle_first", i), ang_q[ba], rows[i].ang_first);
        check($sformatf("row%0d_data_first", i), smp_d_q[bs], rows[i].dat_first);
        check($sformatf("row%0d_angle_last", i), ang_q[ba+n-1], rows[i].ang_last);
        check($sformatf("row%0d_voice_last", i), smp_v_q[bs+n-1], rows[i].voice_last);
      end
      if (rows[i].en[0] && start_cyc_q.size() > bsc)
        check($sformatf("row%0d_start_latency", i), start_cyc_q[bsc] - t0, 2);
      if (rows[i].exp_n == 8 && n == 8)
        for (int k = 0; k < 8; k++) check($sformatf("all_en_order%0d", k), smp_v_q[bs+k], k);
    end
    check("valid_to_sample_latency", lat_bad, 0);

    // Second tick during WAIT is dropped and latches overrun.
    do_reset(2);
    check("overrun_after_reset", overrun, 0);
    voice_en = 8'h01;
    bs = smp_v_q.size(); bsc = start_cyc_q.size();
    pulse_tick(t0);
    got = 0;
    for (int k = 0; k < 50 && got == 0; k++) begin
      if (start_cyc_q.size() > bsc) got = 1; else @(negedge clk);
    end
    check("ovr_start_seen", got, 1);
    repeat (3) @(negedge clk);
    pulse_tick(t0);
    check("ovr_set", overrun, 1);
    wait_done(done_at, got);
    repeat (60) @(negedge clk);
    check("ovr_no_extra_frame_starts", start_cyc_q.size() - bsc, 1);
    check("ovr_no_extra_frame_samples", smp_v_q.size() - bs, 1);
    pulse_tick(t0);
    wait_done(done_at, got);
    @(negedge clk);
    check("ovr_sticky", overrun, 1);

    // Tick landing on the frame_done cycle counts as overrun.
    do_reset(2);
    voice_en = 8'h00;
    bd = done_cnt;
    pulse_tick(t0);
    wait_done(done_at, got);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (15) @(negedge clk);
    check("done_tick_overrun", overrun, 1);
    check("done_tick_no_frame", done_cnt - bd, 1);

    // Busy held high in ISSUE delays the start to a single pulse.
    do_reset(2);
    voice_en = 8'h01;
    hold_busy = 1'b1;
    bs = smp_v_q.size(); bsc = start_cyc_q.size();
    pulse_tick(t0);
    repeat (6) @(negedge clk);
    check("busy_no_start", start_cyc_q.size() - bsc, 0);
    hold_busy = 1'b0;
    wait_done(done_at, got);
    check("busy_done_seen", got, 1);
    check("busy_one_start", start_cyc_q.size() - bsc, 1);
    check("busy_one_sample", smp_v_q.size() - bs, 1);
    check("start_while_busy", start_busy_bad, 0);

    // Delta write during the EMIT cycle applies from the next update onward.
    do_reset(2);
    write_delta(3'd0, 30'h10000000);
    voice_en = 8'h01;
    ba = ang_q.size();
    pulse_tick(t0);
    got = 0;
    for (int k = 0; k < 100 && got == 0; k++) begin
      if (smp_valid) got = 1; else @(negedge clk);
    end
    check("cfg_emit_seen", got, 1);
    cfg_we = 1'b1; cfg_voice = 3'd0; cfg_delta = 30'h08000000;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_done(done_at, got);
    pulse_tick(t0);
    wait_done(done_at, got);
    pulse_tick(t0);
    wait_done(done_at, got);
    @(negedge clk);
    if (ang_q.size() - ba == 3) begin
      check("cfg_frame1_angle", ang_q[ba], 24'h000000);
      check("cfg_frame2_old_delta", ang_q[ba+1], 24'h200000);
      check("cfg_frame3_new_delta", ang_q[ba+2], 24'h300000);
    end else begin
      check("cfg_frame_starts", ang_q.size() - ba, 3);
    end

    // Reset during WAIT aborts the frame; the late core valid is ignored.
    do_reset(2);
    voice_en = 8'h01;
    write_delta(3'd0, 30'h20000000);
    bs = smp_v_q.size(); bsc = start_cyc_q.size(); bd = done_cnt;
    pulse_tick(t0);
    got = 0;
    for (int k = 0; k < 50 && got == 0; k++) begin
      if (start_cyc_q.size() > bsc) got = 1; else @(negedge clk);
    end
    check("rst_wait_start_seen", got, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait_ctrl", {27'd0, cordic_start, smp_valid, frame_done, overrun, smp_voice}, 32'd0);
    check("rst_wait_data", {16'd0, smp_data}, 32'd0);
    check("rst_wait_angle", {8'd0, cordic_angle}, 32'd0);
    repeat (40) @(negedge clk);
    check("rst_wait_no_sample", smp_v_q.size() - bs, 0);
    check("rst_wait_no_done", done_cnt - bd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_voice_sched.md
CORDIC_VOICE_SCHED -- requirements
Module: cordic_voice_sched

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, meaning the number of oscillator voices sharing one CORDIC sine core (power of two, 2..16).
REQ-002 SHALL have parameter VW, default $clog2(NUM_VOICES), meaning the voice index width.
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port sample_tick, input, 1: one-cycle pulse that starts a new frame, with one sample per enabled voice.
REQ-006 Port voice_en, input, NUM_VOICES: per-voice enable mask, sampled when a voice is visited.
REQ-007 Port cfg_we / cfg_voice / cfg_delta, input, 1 / VW / 30: delta-angle write; cfg_delta is unsigned Q1.29 radians (0 to 1.999...).
REQ-008 Port cordic_angle, output, 24: angle to the core, equal to phase bits [30:7].
REQ-009 Port cordic_start, output, 1: one-cycle start pulse to the core.
REQ-010 Port cordic_busy / cordic_out_valid, input, 1 / 1: core status.
REQ-011 Port cordic_out, input, 16: core result, sin of |angle| in two's complement.
REQ-012 Port smp_valid / smp_voice / smp_data, output, 1 / VW / 16: per-voice sample strobe, index, and signed value.
REQ-013 Port frame_done, output, 1: one-cycle pulse after the last voice of a frame.
REQ-014 Port overrun, output, 1: sticky flag, set when sample_tick arrives while a frame is in progress.

Function
REQ-015 State per voice SHALL be:
  - phase[v]: signed 32-bit Q3.29, kept in [-pi/2, pi/2].
  - neg[v]: 1-bit negate flag.
  - delta[v]: 30-bit delta angle.
REQ-016 The FSM states SHALL be IDLE, SCAN, ISSUE, WAIT and EMIT.
REQ-017 The FSM transitions SHALL be:
  - IDLE + sample_tick -> SCAN, with v = 0.
  - SCAN, voice_en[v] = 1 -> ISSUE.
  - SCAN, voice_en[v] = 0 -> skip voice v (phase held, no sample); go to SCAN at v+1, or to IDLE with frame_done if v is last.
  - ISSUE -> WAIT.
  - WAIT + cordic_out_valid -> EMIT.
  - EMIT -> SCAN at v+1, or -> IDLE with frame_done if v is last.
REQ-018 In ISSUE, cordic_start SHALL assert for exactly one cycle when cordic_busy = 0, with cordic_angle = phase[v][30:7]; while cordic_busy = 1, the FSM SHALL hold in ISSUE with cordic_start = 0.
REQ-019 cordic_start SHALL never assert outside ISSUE.
REQ-020 cordic_out_valid outside WAIT SHALL be ignored.
REQ-021 In EMIT, smp_valid SHALL be 1 for one cycle, with smp_voice = v and smp_data = neg[v] ? -cordic_out : cordic_out, using the captured cordic_out and the pre-update neg[v].
REQ-022 In the EMIT cycle, phase update: t = phase[v] + zero-extended delta[v] (32-bit); if t > PI/2 (0x3243F6A8, and t non-negative), phase[v] <= t - PI (PI = 0x6487ED51) and neg[v] toggles; else phase[v] <= t.
REQ-023 A single subtraction SHALL suffice because delta < PI.
REQ-024 Output latency:
  - sample_tick at cycle T with core idle -> cordic_start at T+2 for voice 0 (if enabled).
  - cordic_out_valid at cycle C -> smp_valid at C+1.
REQ-025 sample_tick outside IDLE SHALL be dropped and SHALL set overrun; overrun clears only on rst.
REQ-026 cfg_we SHALL write delta[cfg_voice] on the same edge.
REQ-027 A write coincident with that voice's EMIT SHALL take effect on the next frame; the update uses the old delta.
REQ-028 All voices disabled SHALL give a frame of NUM_VOICES+1 cycles with no samples, ending with frame_done.
REQ-029 sample_tick coinciding with the frame_done cycle SHALL count as an overrun.

Reset
REQ-030 On rst, all phase, neg and delta SHALL be 0 and the state SHALL be IDLE.
REQ-031 On rst, cordic_start, smp_valid, frame_done and overrun SHALL be 0, and smp_data, smp_voice and cordic_angle SHALL be 0.
REQ-032 rst mid-frame SHALL abort the frame without emitting a sample; any later core cordic_out_valid SHALL be ignored.

Verification
REQ-033 Bench SHALL use a core stub: busy for 20 cycles after start, then cordic_out_valid with cordic_out = 0x4000.
REQ-034 Phase fold: voice0 delta = 0x20000000, others disabled, three ticks -> cordic_angle 0x000000, then 0x400000, then 0xB6F025; smp_data 0x4000, 0x4000, then 0xC000 (neg set after phase 0xDB7812AF).
REQ-035 All 8 voices enabled, one tick -> eight smp_valid with smp_voice 0..7 in order, each one cycle after its cordic_out_valid; frame_done once after voice 7.
REQ-036 voice_en = 0x05 -> samples only for voices 0 and 2; phases of voices 1 and 3..7 unchanged after the frame.
REQ-037 Second sample_tick during WAIT -> overrun = 1 and no extra frame; overrun stays set until rst.
REQ-038 cordic_busy held high 5 extra cycles in ISSUE -> no cordic_start until busy falls, then exactly one pulse.
REQ-039 cfg_we to voice 0 in its EMIT cycle -> that update uses the old delta; the next frame uses the new delta.
REQ-040 rst asserted during WAIT -> IDLE and all outputs 0 next cycle; the stub's late valid produces no smp_valid.
